// File: rtl/ascii_num_parser.sv
// Walks a validated ASCII payload one character per cycle and emits each space-separated,
// optionally negative decimal token as a signed integer on a valid/ready stream.
module ascii_num_parser #(
    parameter int unsigned MAX_PAYLOAD = 2048,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MAX_NUMS    = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic                           clear_i,
    input  logic [15:0]                    buffer_length_i,
    output logic [$clog2(MAX_PAYLOAD)-1:0] char_addr_o,
    input  logic [7:0]                     char_data_i,
    output logic [DATA_WIDTH-1:0]          num_data_o,
    output logic                           num_valid_o,
    input  logic                           num_ready_i,
    output logic [15:0]                    num_count_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           error_o
);

    localparam int unsigned AW   = $clog2(MAX_PAYLOAD);
    localparam int unsigned AccW = DATA_WIDTH + 4;
    localparam logic [AccW-1:0] LimNeg  = AccW'(1) << (DATA_WIDTH - 1);
    localparam logic [AccW-1:0] LimPos  = LimNeg - AccW'(1);
    localparam logic [15:0]     MaxLen  = 16'(MAX_PAYLOAD);
    localparam logic [15:0]     MaxNums = 16'(MAX_NUMS);

    typedef enum logic [2:0] {StIdle, StScan, StEmit, StDone, StErr} state_e;

    state_e                state_q, state_d;
    logic [15:0]           addr_q, addr_d;
    logic [AccW-1:0]       acc_q, acc_d;
    logic                  neg_q, neg_d;
    logic                  in_num_q, in_num_d;
    logic [DATA_WIDTH-1:0] num_data_q, num_data_d;
    logic                  num_valid_q, num_valid_d;
    logic [15:0]           num_count_q, num_count_d;
    logic                  busy_q, done_q, error_q;

    logic [15:0]     len_eff;
    logic            at_end, is_digit, is_space, is_minus, ovf, term;
    logic [AccW-1:0] acc_next;

    // The address counter is wider than char_addr_o so it can reach a full-depth length.
    assign len_eff  = (buffer_length_i > MaxLen) ? MaxLen : buffer_length_i;
    assign at_end   = (addr_q == len_eff);
    assign is_digit = (char_data_i >= 8'h30) && (char_data_i <= 8'h39);
    assign is_space = (char_data_i == 8'h20);
    assign is_minus = (char_data_i == 8'h2D);
    assign acc_next = acc_q * AccW'(10) + AccW'(char_data_i[3:0]);
    assign ovf      = neg_q ? (acc_next > LimNeg) : (acc_next > LimPos);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        in_num_d    = in_num_q;
        num_data_d  = num_data_q;
        num_valid_d = num_valid_q;
        num_count_d = num_count_q;
        term        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d  = StScan;
                    addr_d   = '0;
                    acc_d    = '0;
                    neg_d    = 1'b0;
                    in_num_d = 1'b0;
                end
            end
            StScan: begin
                if (at_end) begin
                    if (in_num_q)   term    = 1'b1;
                    else if (neg_q) state_d = StErr;
                    else            state_d = StDone;
                end else if (is_digit) begin
                    acc_d    = acc_next;
                    in_num_d = 1'b1;
                    addr_d   = addr_q + 16'd1;
                    if (ovf) state_d = StErr;
                end else if (is_minus) begin
                    if (!in_num_q && !neg_q) begin
                        neg_d  = 1'b1;
                        addr_d = addr_q + 16'd1;
                    end else begin
                        state_d = StErr;
                    end
                end else if (is_space) begin
                    if (in_num_q) begin
                        term   = 1'b1;
                        addr_d = addr_q + 16'd1;
                    end else if (neg_q) begin
                        state_d = StErr;
                    end else begin
                        addr_d = addr_q + 16'd1;
                    end
                end else begin
                    state_d = StErr;
                end
                if (term) begin
                    if (num_count_q >= MaxNums) begin
                        state_d = StErr;
                    end else begin
                        state_d     = StEmit;
                        num_valid_d = 1'b1;
                        num_data_d  = DATA_WIDTH'(neg_q ? -acc_q : acc_q);
                    end
                end
            end
            StEmit: begin
                if (num_ready_i) begin
                    num_valid_d = 1'b0;
                    num_count_d = num_count_q + 16'd1;
                    acc_d       = '0;
                    neg_d       = 1'b0;
                    in_num_d    = 1'b0;
                    state_d     = (addr_q >= len_eff) ? StDone : StScan;
                end
            end
            StDone, StErr: ;
            default: state_d = StIdle;
        endcase
        if (state_d == StErr) num_valid_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            in_num_q    <= 1'b0;
            num_data_q  <= '0;
            num_valid_q <= 1'b0;
            num_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            in_num_q    <= in_num_d;
            num_data_q  <= num_data_d;
            num_valid_q <= num_valid_d;
            num_count_q <= num_count_d;
            busy_q      <= (state_d == StScan) || (state_d == StEmit);
            done_q      <= (state_d == StDone);
            error_q     <= (state_d == StErr);
        end
    end

    assign char_addr_o = addr_q[AW-1:0];
    assign num_data_o  = num_data_q;
    assign num_valid_o = num_valid_q;
    assign num_count_o = num_count_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

endmodule
